// File: rtl/mor1kx_gpr_spr_initiator_pkg.sv
// Shared constants for GPR access over the SPR bus: group-0 GPR window at 0x400+n
// and the initiator FSM state encoding.
package mor1kx_gpr_spr_initiator_pkg;

  localparam logic [15:0] SPR_GPR_BASE = 16'h0400;
  localparam int          SPR_GRP_LSB  = 9;
  localparam logic [6:0]  SPR_GRP0_GPR = 7'h2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_STALL = 2'd1,
    ST_BUS        = 2'd2,
    ST_RESP       = 2'd3
  } state_t;

  // Group field on top, 9-bit zero-extended GPR index below it.
  function automatic logic [15:0] gpr_spr_addr(input logic [8:0] idx);
    logic [15:0] a;
    a = SPR_GPR_BASE;
    a[15:SPR_GRP_LSB] = SPR_GRP0_GPR;
    a[SPR_GRP_LSB-1:0] = idx;
    return a;
  endfunction

endpackage

// File: rtl/mor1kx_gpr_spr_initiator.sv
// SPR-bus initiator for debug/context-switch GPR reads and writes; one access at a time,
// handshake to first strobe is 1 cycle when stalled, response held until rsp_ready_i.
module mor1kx_gpr_spr_initiator
  import mor1kx_gpr_spr_initiator_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int RF_ADDR_WIDTH        = 5,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_stalled_i,
  input  logic                            abort_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_we_i,
  input  logic [RF_ADDR_WIDTH-1:0]        req_gpr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] req_wdata_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic [15:0]                     spr_bus_addr_o,
  output logic                            spr_bus_stb_o,
  output logic                            spr_bus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
  input  logic                            spr_gpr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i
);

  localparam int             CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit             TMO_EN   = (TIMEOUT_CYCLES > 0);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             req_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      req_ready_o    <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_err_o      <= 1'b0;
      rsp_rdata_o    <= '0;
      spr_bus_stb_o  <= 1'b0;
      spr_bus_we_o   <= 1'b0;
      spr_bus_addr_o <= '0;
      spr_bus_dat_o  <= '0;
      req_we         <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o    <= 1'b0;
            req_we         <= req_we_i;
            spr_bus_addr_o <= gpr_spr_addr(9'(req_gpr_i));
            spr_bus_dat_o  <= req_wdata_i;
            state          <= ST_WAIT_STALL;
          end
        end

        ST_WAIT_STALL: begin
          if (abort_i) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            state       <= ST_RESP;
          end else if (cpu_stalled_i) begin
            spr_bus_stb_o <= 1'b1;
            spr_bus_we_o  <= req_we;
            tmo_cnt       <= '0;
            state         <= ST_BUS;
          end
        end

        // Ack has priority over a same-cycle abort or timeout expiry.
        ST_BUS: begin
          if (spr_gpr_ack_i) begin
            spr_bus_stb_o <= 1'b0;
            spr_bus_we_o  <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b0;
            rsp_rdata_o   <= req_we ? '0 : spr_gpr_dat_i;
            state         <= ST_RESP;
          end else if (abort_i || (TMO_EN && tmo_cnt == CNT_LAST)) begin
            spr_bus_stb_o <= 1'b0;
            spr_bus_we_o  <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_rdata_o   <= '0;
            state         <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            req_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
